// File: rtl/data_memory.sv
// Word-organised data memory: combinational sign/zero-extending loads, byte-lane stores,
// misalign/out-of-range detection. Define DM_TRACE_EN to print every committed store.
module data_memory #(
  parameter int DEPTH_LOG2     = 10,
  parameter bit TRACE_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic [1:0]  st_type,
  input  logic [2:0]  ld_type,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        out_of_range
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {ST_W = 2'b00, ST_H = 2'b01, ST_B = 2'b10, ST_RSV = 2'b11} st_e;
  typedef enum logic [2:0] {
    LD_W = 3'b000, LD_H = 3'b001, LD_HU = 3'b010, LD_B = 3'b011, LD_BU = 3'b100
  } ld_e;

  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           raw;
  logic [31:0]           wmerge;
  logic [15:0]           half;
  logic [7:0]            byt;
  logic                  we;

  assign idx = addr[DEPTH_LOG2+1:2];
  assign raw = mem[idx];

  // Any set bit above the array span is out of range; no aliasing back into the array.
  assign out_of_range = |addr[31:DEPTH_LOG2+2];

  always_comb begin
    misalign = 1'b0;
    if (mem_write) begin
      case (st_e'(st_type))
        ST_W:    misalign = |addr[1:0];
        ST_H:    misalign = addr[0];
        default: misalign = 1'b0;
      endcase
    end else begin
      case (ld_e'(ld_type))
        LD_H, LD_HU: misalign = addr[0];
        LD_B, LD_BU: misalign = 1'b0;
        default:     misalign = |addr[1:0];
      endcase
    end
  end

  assign we = mem_write && (st_type != ST_RSV) && !misalign && !out_of_range;

  always_comb begin
    wmerge = raw;
    case (st_e'(st_type))
      ST_W: wmerge = wdata;
      ST_H: if (addr[1]) wmerge[31:16] = wdata[15:0];
            else         wmerge[15:0]  = wdata[15:0];
      ST_B: wmerge[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
      default: wmerge = raw;
    endcase
  end

  assign half = addr[1] ? raw[31:16] : raw[15:0];
  assign byt  = raw[{addr[1:0], 3'b000} +: 8];

  always_comb begin
    rdata = raw;
    case (ld_e'(ld_type))
      LD_H:    rdata = {{16{half[15]}}, half};
      LD_HU:   rdata = {16'h0, half};
      LD_B:    rdata = {{24{byt[7]}}, byt};
      LD_BU:   rdata = {24'h0, byt};
      default: rdata = raw;
    endcase
    if (out_of_range || misalign) rdata = '0;
  end

  // Reset wins over a simultaneous store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wmerge;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      if (TRACE_ON_RESET) $display("@%08h: reset", pc);
    end else if (we) begin
      $display("@%08h: *%08h <= %08h", pc, {addr[31:2], 2'b00}, wmerge);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  localparam bit unused_trace_rst = TRACE_ON_RESET;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: byte-addressed reference model checked every cycle,
// plus literal expectations from hand-computed vectors.
module tb_data_memory;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, addr, wdata;
  logic        mem_write;
  logic [1:0]  st_type;
  logic [2:0]  ld_type;
  logic [31:0] rdata;
  logic        misalign, out_of_range;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic [7:0] mb [4096];

  data_memory #(.DEPTH_LOG2(10), .TRACE_ON_RESET(1'b0)) dut (
    .clk(clk), .reset(reset), .pc(pc), .addr(addr), .wdata(wdata),
    .mem_write(mem_write), .st_type(st_type), .ld_type(ld_type),
    .rdata(rdata), .misalign(misalign), .out_of_range(out_of_range)
  );

  always #5 clk = ~clk;

  function automatic bit m_oor(logic [31:0] a);
    return a >= 32'd4096;
  endfunction

  function automatic bit m_mis(logic mw, logic [1:0] st, logic [2:0] ld, logic [31:0] a);
    int sz;
    if (mw) sz = (st == 2'd0) ? 4 : (st == 2'd1) ? 2 : 1;
    else    sz = (ld == 3'd1 || ld == 3'd2) ? 2 : (ld == 3'd3 || ld == 3'd4) ? 1 : 4;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] m_load(logic mw, logic [1:0] st, logic [2:0] ld,
                                         logic [31:0] a);
    int b;
    logic [15:0] h;
    logic [7:0]  c;
    if (m_oor(a) || m_mis(mw, st, ld, a)) return 32'h0;
    b = int'(a);
    c = mb[b];
    h = {mb[(b & ~1) + 1], mb[b & ~1]};
    case (ld)
      3'd1:    return 32'(signed'(h));
      3'd2:    return {16'h0, h};
      3'd3:    return 32'(signed'(c));
      3'd4:    return {24'h0, c};
      default: return {mb[(b & ~3) + 3], mb[(b & ~3) + 2], mb[(b & ~3) + 1], mb[b & ~3]};
    endcase
  endfunction

  // Model commit: same edge the DUT stores on.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
    end else if (mem_write === 1'b1 && st_type != 2'd3 &&
                 !m_oor(addr) && !m_mis(1'b1, st_type, ld_type, addr)) begin
      for (int k = 0; k < (st_type == 2'd0 ? 4 : st_type == 2'd1 ? 2 : 1); k++)
        mb[int'(addr) + k] = wdata[8*k +: 8];
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic [31:0] er;
      logic        em, eo;
      er = m_load(mem_write, st_type, ld_type, addr);
      em = m_mis(mem_write, st_type, ld_type, addr);
      eo = m_oor(addr);
      checks++;
      if (rdata !== er || misalign !== em || out_of_range !== eo) begin
        errors++;
        $display("FAIL model addr=%08h: got rdata=%08h mis=%b oor=%b, want rdata=%08h mis=%b oor=%b",
                 addr, rdata, misalign, out_of_range, er, em, eo);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, return mid-cycle once outputs have settled.
  task automatic op(input logic rst, input logic mw, input logic [1:0] st,
                    input logic [2:0] ld, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    reset = rst; mem_write = mw; st_type = st; ld_type = ld; addr = a; wdata = wd;
    pc = pc + 32'd4;
    @(negedge clk); #1;
  endtask

  task automatic ld(input logic [2:0] t, input logic [31:0] a);
    op(1'b0, 1'b0, 2'd0, t, a, 32'h0);
  endtask

  task automatic st(input logic [1:0] t, input logic [31:0] a, input logic [31:0] wd);
    op(1'b0, 1'b1, t, 3'd0, a, wd);
  endtask

  initial begin
    reset = 1'b1; mem_write = 1'b0; st_type = 2'd0; ld_type = 3'd0;
    addr = 32'h0; wdata = 32'h0; pc = 32'h0040_0000;
    op(1'b1, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
    check_en = 1'b1;

    ld(3'd0, 32'h0);    lit("rst_lw0", rdata, 32'h0);
    lit("rst_flags", {30'h0, misalign, out_of_range}, 32'h0);
    ld(3'd0, 32'h7FC);  lit("rst_lw7fc", rdata, 32'h0);
    ld(3'd0, 32'hFFC);  lit("rst_lwffc", rdata, 32'h0);
    lit("rst_ffc_flags", {30'h0, misalign, out_of_range}, 32'h0);

    st(2'd0, 32'h10, 32'h1234_5678);
    st(2'd2, 32'h11, 32'h0000_00AB);
    ld(3'd0, 32'h10);   lit("sb_merge_lw", rdata, 32'h1234_AB78);
    ld(3'd3, 32'h11);   lit("lb_sext", rdata, 32'hFFFF_FFAB);
    ld(3'd4, 32'h11);   lit("lbu_zext", rdata, 32'h0000_00AB);

    st(2'd1, 32'h22, 32'h0000_8001);
    ld(3'd1, 32'h22);   lit("lh_sext", rdata, 32'hFFFF_8001);
    ld(3'd2, 32'h22);   lit("lhu_zext", rdata, 32'h0000_8001);
    ld(3'd0, 32'h20);   lit("sh_upper_lw", rdata, 32'h8001_0000);

    st(2'd0, 32'h13, 32'hDEAD_BEEF);
    lit("sw_mis_flag", {31'h0, misalign}, 32'h1);
    ld(3'd0, 32'h10);   lit("sw_mis_nowrite", rdata, 32'h1234_AB78);
    ld(3'd1, 32'h21);   lit("lh_mis_flag", {31'h0, misalign}, 32'h1);
    lit("lh_mis_rdata", rdata, 32'h0);
    ld(3'd7, 32'h12);   lit("ld_other_mis", {31'h0, misalign}, 32'h1);

    st(2'd0, 32'h0, 32'h55AA_55AA);
    st(2'd0, 32'h1000, 32'hFFFF_FFFF);
    lit("sw_oor_flag", {31'h0, out_of_range}, 32'h1);
    ld(3'd0, 32'h0);    lit("oor_no_alias", rdata, 32'h55AA_55AA);
    ld(3'd0, 32'h8000_0000); lit("oor_high_rdata", rdata, 32'h0);

    st(2'd3, 32'h40, 32'h7777_7777);
    ld(3'd0, 32'h40);   lit("st_rsv_nowrite", rdata, 32'h0);

    st(2'd0, 32'h30, 32'hCAFE_F00D);
    lit("same_cycle_old", rdata, 32'h0);
    ld(3'd0, 32'h30);   lit("next_cycle_new", rdata, 32'hCAFE_F00D);

    st(2'd0, 32'h4, 32'h1111_1111);
    op(1'b1, 1'b1, 2'd0, 3'd0, 32'h4, 32'hFFFF_FFFF);
    ld(3'd0, 32'h4);    lit("rst_beats_store", rdata, 32'h0);
    ld(3'd0, 32'h10);   lit("rst_clears_all", rdata, 32'h0);
    ld(3'd0, 32'hFFC);  lit("rst_top_word", rdata, 32'h0);

    @(posedge clk); #1;
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory for the single-cycle datapath, sitting directly downstream of the ALU. It takes the ALU result as a byte address and performs word, halfword and byte stores on the clock edge. Loads are combinational, with sign or zero extension, and return to the register-file write-back mux in the same cycle. Misaligned and out-of-range accesses are detected and flagged; the offending store is suppressed.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: log2 of the number of 32-bit words (1024 words = 4 KiB, byte addresses 0x0000–0x0FFF).
- `TRACE_ON_RESET`, 0: when 1 and tracing is compiled in, reset cycles are also printed.

Ports:
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high. Clears every word to 0 on the next rising edge.
- `pc`, input, 32: PC of the current instruction; used only for the trace.
- `addr`, input, 32: byte address, driven by the ALU result.
- `wdata`, input, 32: store data (rt value).
- `mem_write`, input, 1: store enable.
- `st_type`, input, 2: 00 = sw, 01 = sh, 10 = sb, 11 = reserved (no write).
- `ld_type`, input, 3: 000 = lw, 001 = lh, 010 = lhu, 011 = lb, 100 = lbu, others = lw.
- `rdata`, output, 32: load result after extension.
- `misalign`, output, 1: the access is misaligned for the selected type.
- `out_of_range`, output, 1: `addr` ≥ 4·2^DEPTH_LOG2.

## Operation
- Storage: `mem[0 .. 2^DEPTH_LOG2−1]`, 32 bits each, little-endian byte lanes.
  - Word index = `addr[DEPTH_LOG2+1:2]`.
  - Byte lane = `addr[1:0]`.
- Alignment check uses `mem_write ? st_type : ld_type`:
  - sw/lw require `addr[1:0]` = 00.
  - sh/lh/lhu require `addr[0]` = 0.
  - Byte accesses are always aligned.
- Store, when `mem_write` is high, no reset, `st_type` ≠ 11, not misaligned and not out of range:
  - sw writes all 4 lanes with `wdata`.
  - sh writes lanes {1,0} or {3,2} with `wdata[15:0]`, selected by `addr[1]`.
  - sb writes lane `addr[1:0]` with `wdata[7:0]`.
  - Unselected lanes keep their value.
- Suppressed stores leave memory unchanged. `misalign` and `out_of_range` still assert.
- Load:
  - Raw word = `mem[index]`.
  - lh/lb sign-extend the selected half or byte; lhu/lbu zero-extend it.
  - Out of range → `rdata` = 0.
  - Misaligned load → `rdata` = 0.
- `rdata` and both flags are purely combinational from the current inputs and memory contents.

## Timing
- Load latency: 0 cycles (combinational). Store latency: committed at the rising edge ending the cycle.
- Read and write to the same word in one cycle: `rdata` shows the old contents during that cycle and the new contents in the following cycle. There is no bypass.
- Reset:
  - All words read 0 from the cycle after a reset edge.
  - Reset has priority over a simultaneous store, which is dropped.
- Reset mid-program: memory clears regardless of `mem_write`. No state other than the array exists.
- Output values after reset: `rdata` = 0 for any in-range aligned address. The flags depend only on the current `addr` and type.
- Wrap-around: none. Addresses beyond the range never alias into the array.

## Configuration
- `DM_TRACE_EN`
  - Defined: every committed store prints `@<pc>: *<word-aligned addr> <= <full new word>` via `$display` at the commit edge, in hex with 8 digits. Suppressed stores print nothing. Reset prints only when `TRACE_ON_RESET` = 1.
  - Undefined: no trace logic. The `pc` port exists but is unused. Functional behaviour is identical.

## Test plan
- Reset held 1 cycle, then lw at 0x0, 0x7FC and 0xFFC → `rdata` = 0x00000000 for each; flags 0.
- sw 0x12345678 @0x10, then sb 0xAB @0x11, then lw @0x10 → 0x1234AB78. Then lb @0x11 → 0xFFFFFFAB; lbu @0x11 → 0x000000AB.
- sh 0x8001 @0x22, then lh @0x22 → 0xFFFF8001. Then lhu @0x22 → 0x00008001. Then lw @0x20 → 0x80010000.
- sw @0x13 with `wdata` 0xDEADBEEF → `misalign` = 1, no write, and a subsequent lw @0x10 is unchanged. lh @0x21 → `misalign` = 1, `rdata` = 0.
- sw @0x1000 → `out_of_range` = 1 and no write. lw @0x0 still returns its prior value.
- Same cycle: `reset` = 1 with sw 0xFFFFFFFF @0x4 → next cycle lw @0x4 = 0. Also, sw then lw to the same word in one cycle → old value in that cycle, new value in the next.
